seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the 32-bit hex value shown by the multiplexed 8-digit seven-segment
// driver by watching its active-low segment and anode lines.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2097152
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  seg,
  input  logic [7:0]  an,
  output logic [31:0] x,
  output logic        x_valid,
  output logic        locked,
  output logic        err_seg,
  output logic        err_an
);

  // x_valid is a single-cycle strobe with no back-pressure: x is guaranteed
  // to hold the new frame in the cycle x_valid is high and until the next one.
  localparam int DW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYCLES);
  localparam logic [DW-1:0] DWELL_PRE = DW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_PRE = TW'(TIMEOUT - 1);

  logic [6:0]    seg_r;
  logic [7:0]    an_r;
  logic [DW-1:0] dwell;
  logic          fresh;
  logic          hit;
  logic [31:0]   shadow;
  logic [7:0]    seen;
  logic [TW-1:0] timer;

  // Returns {legal, nibble} for an active-low gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic        an_idle;
  logic        an_onehot;
  logic [2:0]  idx;
  logic        glyph_ok;
  logic [3:0]  nib;
  logic        sample;
  logic        legal;
  logic        bad_an;
  logic        timeout_hit;
  logic [31:0] shadow_upd;
  logic [7:0]  seen_upd;

  always_comb begin
    an_idle   = (an_r == 8'hFF);
    an_onehot = $onehot(~an_r);
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!an_r[k]) idx = 3'(k);
    end
    {glyph_ok, nib} = decode(seg_r);
    sample      = hit && an_onehot;
    legal       = sample && glyph_ok;
    bad_an      = fresh && !an_idle && !an_onehot;
    timeout_hit = !legal && (timer >= TIMER_PRE);
    shadow_upd  = shadow;
    shadow_upd[{idx, 2'b00} +: 4] = nib;
    seen_upd    = seen | (8'h01 << idx);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      seg_r   <= 7'h7F;
      an_r    <= 8'hFF;
      dwell   <= '0;
      fresh   <= 1'b0;
      hit     <= 1'b0;
      shadow  <= '0;
      seen    <= '0;
      timer   <= '0;
      x       <= '0;
      x_valid <= 1'b0;
      locked  <= 1'b0;
      err_seg <= 1'b0;
      err_an  <= 1'b0;
    end else begin
      seg_r <= seg;
      an_r  <= an;
      fresh <= (an != an_r);
      // hit marks the single cycle in which dwell first reaches its ceiling.
      if (an != an_r) begin
        dwell <= DW'(1);
        hit   <= (STABLE_CYCLES == 1);
      end else begin
        if (dwell != DWELL_MAX) dwell <= dwell + DW'(1);
        hit <= (dwell == DWELL_PRE);
      end

      x_valid <= 1'b0;
      err_seg <= 1'b0;
      err_an  <= 1'b0;

      if (legal) begin
        shadow <= shadow_upd;
        timer  <= '0;
        if (seen_upd == 8'hFF) begin
          x       <= shadow_upd;
          x_valid <= 1'b1;
          locked  <= 1'b1;
          seen    <= '0;
        end else begin
          seen <= seen_upd;
        end
      end else begin
        if (timer != TIMER_MAX) timer <= timer + TW'(1);
        if (sample) begin
          err_seg <= 1'b1;
          seen    <= '0;
          locked  <= 1'b0;
        end
        if (bad_an) begin
          err_an <= 1'b1;
          seen   <= '0;
          locked <= 1'b0;
        end
        if (timeout_hit) begin
          seen   <= '0;
          locked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder: a run-length reference model feeds an
// event scoreboard, while x and locked are checked every cycle.
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [7:0]  an  = 8'hFF;
  logic [31:0] x;
  logic        x_valid, locked, err_seg, err_an;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(T)) dut (
    .clk(clk), .clr(clr), .seg(seg), .an(an), .x(x), .x_valid(x_valid),
    .locked(locked), .err_seg(err_seg), .err_an(err_an)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  // event word: {type, x}; type 1 = frame, 2 = bad glyph, 3 = bad anode
  logic [33:0] exp_q[$];

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [7:0]  m_prev_an;
  int          m_run, m_timer;
  logic [31:0] m_shadow, m_x;
  logic [7:0]  m_seen;
  logic        m_locked, m_pend;
  logic        m_pushed = 1'b0;
  logic [31:0] pipe_x [2];
  logic        pipe_lk [2];

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every output pulse is matched against the next expected event.
  always @(negedge clk) begin : monitor
    logic [1:0] typ;
    if (x_valid || err_seg || err_an) begin
      typ = 2'd0;
      if ($countones({x_valid, err_seg, err_an}) == 1)
        typ = x_valid ? 2'd1 : (err_seg ? 2'd2 : 2'd3);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got %h, expected no event at %0t", {typ, x}, $time);
      end else begin
        check("event", {typ, x}, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    m_prev_an = 8'hFF; m_run = 1; m_timer = 0;
    m_shadow = '0; m_x = '0; m_seen = '0; m_locked = 1'b0;
    m_pend = 1'b1;
  endtask

  // One driven input cycle: track how long the raw anode value has been held
  // and act when that hold length reaches S.
  task automatic model_step(input logic [7:0] a, input logic [6:0] s);
    int idx, nib;
    logic smp;
    smp = 1'b0;
    m_pushed = 1'b0;
    if (m_pend) begin
      m_pend = 1'b0;
      if (m_timer < T) m_timer++;
    end
    if (a != m_prev_an) m_run = 1;
    else if (m_run < 1000000) m_run++;
    m_prev_an = a;
    if (a != 8'hFF && $countones(~a) != 1) begin
      if (m_run == 1) begin
        m_seen = '0; m_locked = 1'b0;
        exp_q.push_back({2'd3, m_x}); m_pushed = 1'b1;
      end
    end else if (a != 8'hFF && m_run == S) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (!a[i]) idx = i;
      nib = -1;
      for (int g = 0; g < 16; g++) if (glyph[g] == s) nib = g;
      if (nib >= 0) begin
        m_shadow[idx*4 +: 4] = 4'(nib);
        m_seen[idx] = 1'b1;
        m_timer = 0;
        smp = 1'b1;
        if (m_seen == 8'hFF) begin
          m_x = m_shadow; m_locked = 1'b1; m_seen = '0;
          exp_q.push_back({2'd1, m_x}); m_pushed = 1'b1;
        end
      end else begin
        m_seen = '0; m_locked = 1'b0;
        exp_q.push_back({2'd2, m_x}); m_pushed = 1'b1;
      end
    end
    if (!smp) begin
      if (m_timer < T) m_timer++;
      if (m_timer == T) begin m_locked = 1'b0; m_seen = '0; end
    end
  endtask

  // Model state after stepping cycle k is what the DUT shows one edge after k.
  task automatic cyc(input logic [7:0] a, input logic [6:0] s);
    @(negedge clk);
    check("x", {2'b00, x}, {2'b00, pipe_x[1]});
    check("locked", {33'b0, locked}, {33'b0, pipe_lk[1]});
    an = a; seg = s;
    model_step(a, s);
    pipe_x[1] = pipe_x[0]; pipe_lk[1] = pipe_lk[0];
    pipe_x[0] = m_x;       pipe_lk[0] = m_locked;
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
    for (int c = 0; c < n; c++) cyc(a, s);
  endtask

  task automatic do_clr(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      // an event from the previous cycle would land on the clr edge and vanish
      if (i == 0 && m_pushed && exp_q.size() > 0) void'(exp_q.pop_back());
      m_pushed = 1'b0;
      clr = 1'b1; an = 8'hFF; seg = 7'h7F;
    end
    @(negedge clk);
    check("rst_x", {2'b00, x}, 34'h0);
    check("rst_x_valid", {33'b0, x_valid}, 34'h0);
    check("rst_locked", {33'b0, locked}, 34'h0);
    check("rst_err_seg", {33'b0, err_seg}, 34'h0);
    check("rst_err_an", {33'b0, err_an}, 34'h0);
    clr = 1'b0; an = 8'hFF; seg = 7'h7F;
    model_reset();
    model_step(8'hFF, 7'h7F);
    pipe_x[1] = '0; pipe_lk[1] = 1'b0;
    pipe_x[0] = m_x; pipe_lk[0] = m_locked;
  endtask

  // Scan all 8 digits; optionally shorten one digit, corrupt one, or shuffle order.
  task automatic scan(input logic [31:0] v, input int dw, input int short_dig,
                      input int short_len, input int bad_dig, input bit shuffle);
    int ord [8];
    for (int i = 0; i < 8; i++) ord[i] = i;
    if (shuffle) begin
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end
    for (int k = 0; k < 8; k++) begin
      int d, n;
      logic [6:0] s;
      d = ord[k];
      s = (d == bad_dig) ? 7'h7F : glyph[v[d*4 +: 4]];
      n = (d == short_dig) ? short_len : dw;
      hold(~(8'h01 << d), s, n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    do_clr(2);

    // clean frames of the reference value
    scan(32'h1234ABCD, 8, -1, 0, -1, 1'b0);
    scan(32'h1234ABCD, 8, -1, 0, -1, 1'b0);

    // clr mid-scan, then only half a frame: no publish until a full new set
    scan(32'h5A5A5A5A, 8, -1, 0, -1, 1'b0);
    for (int d = 0; d < 4; d++) hold(~(8'h01 << d), glyph[4'(d + 9)], 8);
    do_clr(3);
    for (int d = 4; d < 8; d++) hold(~(8'h01 << d), glyph[4'(d)], 8);
    scan(32'hFEDC0123, 8, -1, 0, -1, 1'b0);

    // digit 2 too short for a sample, then a full pass
    scan(32'h0F1E2D3C, 8, 2, 3, -1, 1'b0);
    scan(32'h0F1E2D3C, 8, 2, 4, -1, 1'b0);

    // blank glyph on digit 5, then a clean frame
    scan(32'h87654321, 8, -1, 0, 5, 1'b0);
    scan(32'h87654321, 8, -1, 0, -1, 1'b0);

    // two anodes low, then long idle (also runs into the timeout)
    hold(8'b11110011, glyph[3], 10);
    hold(8'hFF, 7'h7F, 100);

    // relock; a sample lands exactly on the timeout threshold; then time out
    scan(32'h13579BDF, 8, -1, 0, -1, 1'b0);
    hold(8'hFF, 7'h7F, 56);
    hold(8'hFE, glyph[4'hF], 8);
    hold(8'hFF, 7'h7F, 70);

    // randomised frames
    for (int it = 0; it < 40; it++) begin
      logic [31:0] v;
      int mode, dw;
      v = $urandom;
      mode = $urandom_range(0, 9);
      dw = $urandom_range(S, 9);
      case (mode)
        0: scan(v, dw, -1, 0, $urandom_range(0, 7), 1'b1);
        1: begin
          int i, j;
          i = $urandom_range(0, 7);
          j = (i + $urandom_range(1, 7)) % 8;
          hold(($urandom_range(0, 3) == 0) ? 8'h00 : ~((8'h01 << i) | (8'h01 << j)),
               glyph[v[3:0]], $urandom_range(1, 6));
          scan(v, dw, -1, 0, -1, 1'b1);
        end
        2: scan(v, dw, $urandom_range(0, 7), $urandom_range(1, S + 2), -1, 1'b1);
        3: begin
          scan(v, dw, -1, 0, -1, 1'b0);
          do_clr($urandom_range(1, 3));
        end
        default: scan(v, dw, -1, 0, -1, 1'b1);
      endcase
      hold(8'hFF, 7'h7F, ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(0, 12));
    end

    hold(8'hFF, 7'h7F, 10);
    check("queue_empty", 34'(exp_q.size()), 34'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
